// File: rtl/xor_bit_deserializer.sv
// Packs a valid-qualified serial bit stream into WIDTH-bit words with even parity,
// presented through a one-entry valid/ready buffer with a sticky overrun flag.
module xor_bit_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             word_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] word_out,
  output logic             parity_out,
  output logic             word_valid,
  output logic [CW-1:0]    bit_count,
  output logic             overrun
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             parity_q, parity_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             load;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      word_q   <= '0;
      parity_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      parity_q <= parity_d;
      ovr_q    <= ovr_d;
    end
  end

  // Collection, buffer load and next-state logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    parity_d = parity_q;
    ovr_d    = ovr_q;

    shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], bit_in} : {bit_in, shreg_q[WIDTH-1:1]};
    complete = bit_valid && (cnt_q == CW'(WIDTH - 1));
    // A completed word is buffered if the slot is free or being drained this edge
    load     = complete && ((state_q == EMPTY) || word_ready);

    if (bit_valid) begin
      if (complete) begin
        shreg_d = '0;
        par_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        shreg_d = shifted;
        par_d   = par_q ^ bit_in;
        cnt_d   = cnt_q + CW'(1);
      end
    end

    if (load) begin
      word_d   = shifted;
      parity_d = par_q ^ bit_in;
    end

    case (state_q)
      EMPTY: if (complete) state_d = FULL;
      FULL:  if (!complete && word_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    // A drop on the same edge as a clear keeps the flag set
    if (overrun_clr) ovr_d = 1'b0;
    if (complete && !load) ovr_d = 1'b1;
  end

  assign word_out   = word_q;
  assign parity_out = parity_q;
  assign word_valid = (state_q == FULL);
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_xor_bit_deserializer.sv
// Directed bench for xor_bit_deserializer: MSB-first and LSB-first instances share stimulus.
module tb_xor_bit_deserializer;

  logic clk = 1'b0;
  logic rst_n, bit_in, bit_valid, word_ready, overrun_clr;
  logic [7:0] m_word, l_word;
  logic       m_par, l_par, m_vld, l_vld, m_ovr, l_ovr;
  logic [3:0] m_cnt, l_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_ready(word_ready), .overrun_clr(overrun_clr), .word_out(m_word),
    .parity_out(m_par), .word_valid(m_vld), .bit_count(m_cnt), .overrun(m_ovr));

  xor_bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_ready(word_ready), .overrun_clr(overrun_clr), .word_out(l_word),
    .parity_out(l_par), .word_valid(l_vld), .bit_count(l_cnt), .overrun(l_ovr));

  typedef struct {
    logic       bi, bv, rdy, clr, rst;
    logic [7:0] ew;
    logic       ep, evld;
    logic [3:0] ecnt;
    logic       eovr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic bi, bv, rdy, clr, rst, input logic [7:0] ew,
                     input logic ep, evld, input logic [3:0] ecnt, input logic eovr);
    vec_t v;
    v.bi = bi; v.bv = bv; v.rdy = rdy; v.clr = clr; v.rst = rst;
    v.ew = ew; v.ep = ep; v.evld = evld; v.ecnt = ecnt; v.eovr = eovr;
    vq.push_back(v);
  endtask

  // Eight MSB-first bits of w; the first seven expect the mid_* buffer state.
  task automatic add_word(input logic [7:0] w, input logic rdy, input logic rdy_last,
                          input logic clr_last,
                          input logic [7:0] mid_w, input logic mid_p, mid_vld, mid_ovr,
                          input logic [7:0] end_w, input logic end_p, end_vld, end_ovr);
    for (int i = 0; i < 7; i++)
      add(w[7-i], 1'b1, rdy, 1'b0, 1'b1, mid_w, mid_p, mid_vld, 4'(i + 1), mid_ovr);
    add(w[0], 1'b1, rdy_last, clr_last, 1'b1, end_w, end_p, end_vld, 4'd0, end_ovr);
  endtask

  task automatic step(input logic bi, bv, rdy, clr, rst);
    bit_in = bi; bit_valid = bv; word_ready = rdy; overrun_clr = clr; rst_n = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] c;

    bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0; overrun_clr = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    // Word B2 with ready high: valid for exactly one cycle
    add_word(8'hB2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 4'd0, 1'b0);
    // B2 then A7 with ready low: second word dropped, B2 held
    add_word(8'hB2, 1'b0, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0);
    add_word(8'hA7, 1'b0, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 4'd0, 1'b0);
    // Completion coinciding with a transfer
    add_word(8'hA7, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0, 8'hA7, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA7, 1'b1, 1'b0, 4'd0, 1'b0);
    // Drop and clear on the same edge: set wins
    add_word(8'hB2, 1'b0, 1'b0, 1'b0, 8'hA7, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0);
    add_word(8'hA7, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 4'd0, 1'b0);
    // Five partial bits while full, then reset mid-word and mid-handshake
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 4'd1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 4'd2, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 4'd3, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 4'd4, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 4'd5, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    add_word(8'hA7, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA7, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA7, 1'b1, 1'b0, 4'd0, 1'b0);

    foreach (vq[i]) begin
      step(vq[i].bi, vq[i].bv, vq[i].rdy, vq[i].clr, vq[i].rst);
      chk($sformatf("v%0d_word", i),  32'(m_word), 32'(vq[i].ew));
      chk($sformatf("v%0d_par", i),   32'(m_par),  32'(vq[i].ep));
      chk($sformatf("v%0d_valid", i), 32'(m_vld),  32'(vq[i].evld));
      chk($sformatf("v%0d_count", i), 32'(m_cnt),  32'(vq[i].ecnt));
      chk($sformatf("v%0d_ovr", i),   32'(m_ovr),  32'(vq[i].eovr));
    end

    // Gapped input: one bit every three cycles
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lsb_rst_word", 32'(l_word), 32'h0);
    chk("lsb_rst_valid", 32'(l_vld), 32'h0);
    b = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      step(b[7-i], 1'b1, 1'b1, 1'b0, 1'b1);
      c = (i == 7) ? 4'd0 : 4'(i + 1);
      chk($sformatf("gap_cnt%0d", i), 32'(m_cnt), 32'(c));
      if (i == 7) begin
        chk("gap_msb_word", 32'(m_word), 32'hB2);
        chk("gap_msb_par", 32'(m_par), 32'h0);
        chk("gap_msb_valid", 32'(m_vld), 32'h1);
        chk("lsb_4d_word", 32'(l_word), 32'h4D);
        chk("lsb_4d_par", 32'(l_par), 32'h0);
        chk("lsb_4d_valid", 32'(l_vld), 32'h1);
      end
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk($sformatf("gap_hold%0d_%0d", i, g), 32'(m_cnt), 32'(c));
      end
    end
    chk("gap_valid_fall", 32'(m_vld), 32'h0);

    // LSB-first A7; the MSB-first instance sees the same bits as E5
    b = 8'hE5;
    for (int i = 0; i < 8; i++) step(b[7-i], 1'b1, 1'b1, 1'b0, 1'b1);
    chk("lsb_a7_word", 32'(l_word), 32'hA7);
    chk("lsb_a7_par", 32'(l_par), 32'h1);
    chk("lsb_a7_valid", 32'(l_vld), 32'h1);
    chk("msb_e5_word", 32'(m_word), 32'hE5);
    chk("msb_e5_par", 32'(m_par), 32'h1);
    chk("lsb_ovr", 32'(l_ovr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
